// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus an optional iterative
// unsigned multiply/divide unit, enabled by defining ALU_MC_MDU_EN.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] hi,
  output logic             zf,
  output logic             of
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpXor  = 4'b0010;
  localparam logic [3:0] OpNor  = 4'b0011;
  localparam logic [3:0] OpAdd  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0101;
  localparam logic [3:0] OpSlt  = 4'b0110;
  localparam logic [3:0] OpSll  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
`ifdef ALU_MC_MDU_EN
  localparam logic [3:0] OpMulu = 4'b1100;
  localparam logic [3:0] OpDivu = 4'b1101;
  localparam int unsigned CntW  = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StDone = 2'd2} state_e;
`else
  typedef enum logic [0:0] {StIdle = 1'b0, StDone = 1'b1} state_e;
`endif

  state_e state_q, state_d;

  logic [WIDTH-1:0] f_q, hi_q;
  logic             zf_q, of_q;
  logic             load_single;

  // Single-cycle datapath, evaluated on the live operands at accept.
  logic             is_sub;
  logic [WIDTH-1:0] add_b, add_sum, res_f;
  logic             res_of;
  logic [SH_W-1:0]  sh;

  assign sh = a[SH_W-1:0];

  always_comb begin
    is_sub  = (op == OpSub);
    add_b   = is_sub ? ~b : b;
    add_sum = a + add_b + WIDTH'(is_sub);
    res_f   = '0;
    res_of  = 1'b0;
    case (op)
      OpAnd:  res_f = a & b;
      OpOr:   res_f = a | b;
      OpXor:  res_f = a ^ b;
      OpNor:  res_f = ~(a | b);
      OpAdd, OpSub: begin
        res_f  = add_sum;
        res_of = (a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSlt:  res_f = WIDTH'($signed(a) < $signed(b));
      OpSltu: res_f = WIDTH'(a < b);
      OpSll:  res_f = b << sh;
      OpSrl:  res_f = b >> sh;
      OpSra:  res_f = $signed(b) >>> sh;
      default: ;
    endcase
  end

`ifdef ALU_MC_MDU_EN
  // Shared accumulator: multiply keeps {partial high, multiplier}, divide keeps
  // {remainder, dividend/quotient}. opnd_q is the multiplicand or divisor.
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, acc_hi_d, acc_lo_d;
  logic             is_div_q;
  logic [CntW-1:0]  cnt_q;
  logic             mdu_start, mdu_step, mdu_last, is_mdu_op;
  logic [WIDTH:0]   mul_sum, div_trial;

  assign is_mdu_op = (op == OpMulu) || (op == OpDivu);

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (is_div_q) begin
      // A borrow out of the trial subtraction means the divisor did not fit: restore.
      if (div_trial[WIDTH]) begin
        acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_hi_d = div_trial[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_hi_d = mul_sum[WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (mdu_start) begin
      is_div_q <= (op == OpDivu);
      acc_hi_q <= '0;
      acc_lo_q <= (op == OpDivu) ? a : b;
      opnd_q   <= (op == OpDivu) ? b : a;
      cnt_q    <= '0;
    end else if (mdu_step) begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    load_single = 1'b0;
`ifdef ALU_MC_MDU_EN
    mdu_start   = 1'b0;
    mdu_step    = 1'b0;
    mdu_last    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
`ifdef ALU_MC_MDU_EN
          if (is_mdu_op) begin
            mdu_start = 1'b1;
            state_d   = StExec;
          end else begin
            load_single = 1'b1;
            state_d     = StDone;
          end
`else
          load_single = 1'b1;
          state_d     = StDone;
`endif
        end
      end
`ifdef ALU_MC_MDU_EN
      StExec: begin
        mdu_step = 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          mdu_last = 1'b1;
          state_d  = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q  <= '0;
      hi_q <= '0;
      zf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (load_single) begin
      f_q  <= res_f;
      hi_q <= '0;
      zf_q <= (res_f == '0);
      of_q <= res_of;
`ifdef ALU_MC_MDU_EN
    end else if (mdu_last) begin
      // Divide-by-zero falls out of the restoring loop as all-ones quotient, remainder = a.
      f_q  <= acc_lo_d;
      hi_q <= acc_hi_d;
      zf_q <= (acc_lo_d == '0);
      of_q <= is_div_q && (opnd_q == '0);
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign f         = f_q;
  assign hi        = hi_q;
  assign zf        = zf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed and random ops against an
// arithmetic reference model, plus handshake, hold and reset-abort scenarios.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, f, hi;
  logic        zf, of;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .hi        (hi),
    .zf        (zf),
    .of        (of)
  );

  // Reference model built from plain integer arithmetic.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] ef, output logic [31:0] eh,
                                output logic ez, output logic eo, output int el);
    longint sx, sy, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ef = 32'd0; eh = 32'd0; eo = 1'b0; el = 1;
    case (o)
      4'd0:  ef = x & y;
      4'd1:  ef = x | y;
      4'd2:  ef = x ^ y;
      4'd3:  ef = ~(x | y);
      4'd4:  begin r = sx + sy; ef = r[31:0]; eo = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd5:  begin r = sx - sy; ef = r[31:0]; eo = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd6:  ef = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  ef = (x < y) ? 32'd1 : 32'd0;
      4'd7:  begin p = {32'd0, y} * (64'd1 << x[4:0]); ef = p[31:0]; end
      4'd9:  ef = y / (32'd1 << x[4:0]);
      4'd10: begin r = sy >>> x[4:0]; ef = r[31:0]; end
`ifdef ALU_MC_MDU_EN
      4'd12: begin p = {32'd0, x} * {32'd0, y}; ef = p[31:0]; eh = p[63:32]; el = 33; end
      4'd13: begin
        el = 33;
        if (y == 32'd0) begin ef = 32'hFFFF_FFFF; eh = x; eo = 1'b1; end
        else begin ef = x / y; eh = x % y; end
      end
`endif
      default: ;
    endcase
    ez = (ef == 32'd0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from IDLE and waits (bounded) for the result; leaves the DUT in DONE.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rf, output logic [31:0] rh, output logic rz,
                       output logic ro, output int lat, output bit busy_ok);
    in_valid = 1'b1; op = o; a = x; b = y;
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      step();
      lat++;
      a = $urandom; b = $urandom;
    end
    if (in_ready) busy_ok = 1'b0;
    in_valid = 1'b0;
    rf = f; rh = hi; rz = zf; ro = of;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    checks++;
    if (f !== 32'd0 || hi !== 32'd0 || zf !== 1'b0 || of !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: f=%h hi=%h zf=%b of=%b, required 0 0 0 0", f, hi, zf, of);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  ops [12] = '{4'd4, 4'd5, 4'd6, 4'd8, 4'd3, 4'd10, 4'd7, 4'd9,
                              4'd12, 4'd13, 4'd13, 4'd14};
    logic [31:0] as  [12] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd4,
                              32'd33, 32'd31, 32'hFFFF_FFFF, 32'd100, 32'd9, 32'd77};
    logic [31:0] bs  [12] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd0, 32'h8000_0000, 32'd1,
                              32'h8000_0000, 32'd2, 32'd7, 32'd0, 32'd88};
    logic [31:0] rf, rh, ef, eh;
    logic        rz, ro, ez, eo;
    int          lat, el;
    bit          busy_ok;
    for (int i = 0; i < 12; i++) begin
      model(ops[i], as[i], bs[i], ef, eh, ez, eo, el);
      issue(ops[i], as[i], bs[i], rf, rh, rz, ro, lat, busy_ok);
      checks++;
      if (rf !== ef || rh !== eh || rz !== ez || ro !== eo || lat != el || !busy_ok) begin
        failures++;
        $display("FAIL directed_%0d op=%h: f=%h hi=%h zf=%b of=%b lat=%0d busy=%b, required %h %h %b %b %0d 1",
                 i, ops[i], rf, rh, rz, ro, lat, busy_ok, ef, eh, ez, eo, el);
      end
      step();
    end
    // Anchor the model with literal values for the overflowing ADD.
    issue(4'd4, 32'h7FFF_FFFF, 32'd1, rf, rh, rz, ro, lat, busy_ok);
    checks++;
    if (rf !== 32'h8000_0000 || ro !== 1'b1 || rz !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL add_overflow_literal: f=%h of=%b zf=%b lat=%0d, required 80000000 1 0 1",
               rf, ro, rz, lat);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] rf, rh, ef, eh, x, y;
    logic        rz, ro, ez, eo;
    logic [3:0]  o;
    int          lat, el;
    bit          busy_ok;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = (i % 7 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      model(o, x, y, ef, eh, ez, eo, el);
      issue(o, x, y, rf, rh, rz, ro, lat, busy_ok);
      checks++;
      if (rf !== ef || rh !== eh || rz !== ez || ro !== eo || lat != el || !busy_ok) begin
        failures++;
        $display("FAIL random_%0d op=%h a=%h b=%h: f=%h hi=%h zf=%b of=%b lat=%0d busy=%b, required %h %h %b %b %0d 1",
                 i, o, x, y, rf, rh, rz, ro, lat, busy_ok, ef, eh, ez, eo, el);
      end
      step();
    end
  endtask

  task automatic test_hold();
    logic [31:0] rf, rh, x, y;
    logic        rz, ro;
    int          lat;
    bit          busy_ok;
    x = $urandom; y = $urandom;
    out_ready = 1'b0;
    issue(4'd13, x, y, rf, rh, rz, ro, lat, busy_ok);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== rf || hi !== rh || zf !== rz ||
          of !== ro) begin
        failures++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b f=%h hi=%h, required 1 0 %h %h",
                 i, out_valid, in_ready, f, hi, rf, rh);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rf, rh, x, y;
    logic        rz, ro;
    int          lat;
    bit          busy_ok;
    x = 32'($urandom_range(0, 1000)); y = 32'($urandom_range(0, 1000));
    issue(4'd4, 32'd10, 32'd20, rf, rh, rz, ro, lat, busy_ok);
    // Request held through the DONE cycle must not be taken until IDLE.
    in_valid = 1'b1; op = 4'd4; a = x; b = y;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_no_accept: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || f !== x + y) begin
      failures++;
      $display("FAIL second_issue: out_valid=%b f=%h, required 1 %h", out_valid, f, x + y);
    end
    step();
  endtask

  task automatic test_reset_abort();
    logic [31:0] rf, rh;
    logic        rz, ro;
    int          lat;
    bit          busy_ok;
    in_valid = 1'b1; op = 4'd12; a = 32'hFFFF_FFFF; b = 32'd2;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || f !== 32'd0 || hi !== 32'd0) begin
      failures++;
      $display("FAIL reset_abort: out_valid=%b in_ready=%b f=%h hi=%h, required 0 1 0 0",
               out_valid, in_ready, f, hi);
    end
    step();
    rst_n = 1'b1;
    step();
    issue(4'd4, 32'd3, 32'd4, rf, rh, rz, ro, lat, busy_ok);
    checks++;
    if (rf !== 32'd7 || rh !== 32'd0 || ro !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL add_after_abort: f=%h hi=%h of=%b lat=%0d, required 7 0 0 1", rf, rh, ro, lat);
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
